// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM state encoding,
// requester port IDs and the wait-state counter width.
package mem_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and loader ports. A tie goes
// to the port that was not granted last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_id_o,
  output logic valid_o
);

  always_comb begin
    // NOTE: every output gets a default first so no latch can be inferred.
    valid_o    = req0_i | req1_i;
    grant_id_o = PORT_CPU;
    if (req0_i && req1_i) begin
      grant_id_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_id_o = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the core's single memory port (IDLE -> ACCESS
// -> RESP). Define ARB_ROUND_ROBIN_EN for round-robin ties; default is loader priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic last_grant;
  logic pick_id;
  logic pick_valid;

  mem_arb_pick u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_grant),
    .grant_id_o   (pick_id),
    .valid_o      (pick_valid)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // Resets to the loader so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= PORT_LDR;
    end else if (state_q == IDLE && pick_valid) begin
      last_q <= pick_id;
    end
  end

  assign last_grant = last_q;
`else
  // Pinning the last grant to the CPU makes the loader win every tie.
  assign last_grant = PORT_CPU;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          cnt_d   = WAIT_INIT;
          owner_d = pick_id;
          we_d    = (pick_id == PORT_LDR) ? we1    : we0;
          addr_d  = (pick_id == PORT_LDR) ? addr1  : addr0;
          wdata_d = (pick_id == PORT_LDR) ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  // The datapath registers are reset as well: mem_addr, mem_wdata and rdata
  // must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The owner register only moves on IDLE->ACCESS; grant_id reads 0 when idle.
  always_comb begin
    busy     = (state_q != IDLE);
    grant_id = busy & owner_q;
    mem_re   = (state_q == ACCESS) & ~we_q;
    mem_we   = (state_q == ACCESS) & we_q & (cnt_q == '0);
    ack0     = (state_q == RESP) & (owner_q == PORT_CPU);
    ack1     = (state_q == RESP) & (owner_q == PORT_LDR);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule
